// File: rtl/mem_access_unit.sv
// MEM stage: sequences data-memory load/store requests and registers the MEM/WB results.
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    input  logic        reg_write_en,
    input  logic [1:0]  wb_sel,
    output logic        stall_o,
    output logic        dm_req,
    output logic        dm_we,
    output logic [3:0]  dm_be,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ready,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_we_o,
    output logic [31:0] wb_data_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT
    } state_t;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    state_t      state;
    state_t      state_nxt;

    logic        is_half;
    logic        is_word;
    logic        mem_op;
    logic        trap;
    logic        go;
    logic        complete;
    logic        wb_load;
    logic [1:0]  lane;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;
    logic [31:0] wb_val;

    assign is_half = (funct3[1:0] == 2'b01);
    assign is_word = funct3[1];
    assign mem_op  = in_valid & (mem_read | mem_write);

    // Lane offset rounded down to the access size; only ever differs from
    // addr[1:0] for a misaligned access.
    always_comb begin
        lane = addr[1:0];
        if (is_word) begin
            lane = 2'b00;
        end else if (is_half) begin
            lane = {addr[1], 1'b0};
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
    assign trap       = mem_op & misaligned;
`else
    assign trap       = 1'b0;
`endif

    assign go = mem_op & ~trap;

    // Stores finish on acceptance; loads only on the response seen in WAIT.
    always_comb begin
        complete = 1'b0;
        if (state == ST_WAIT) begin
            complete = mem_read & dm_rvalid;
        end else begin
            complete = mem_write & dm_ready;
        end
    end

    assign stall_o = ~rst & go & ~complete;

    // ------------------------------------------------------------------
    // Request FSM
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        dm_req    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    dm_req = 1'b1;
                    if (dm_ready) begin
                        state_nxt = mem_write ? ST_IDLE : ST_WAIT;
                    end else begin
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                dm_req = 1'b1;
                if (dm_ready) begin
                    state_nxt = mem_write ? ST_IDLE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm_rvalid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (rst) begin
            dm_req = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request payload
    // ------------------------------------------------------------------
    assign dm_addr = {addr[31:2], 2'b00};
    assign dm_we   = mem_write;

    always_comb begin
        dm_be    = 4'b1111;
        dm_wdata = wdata;
        if (mem_write) begin
            if (is_word) begin
                dm_be    = 4'b1111;
                dm_wdata = wdata;
            end else if (is_half) begin
                dm_be    = 4'b0011 << lane;
                dm_wdata = {2{wdata[15:0]}};
            end else begin
                dm_be    = 4'b0001 << lane;
                dm_wdata = {4{wdata[7:0]}};
            end
        end
    end

    // ------------------------------------------------------------------
    // Load extraction and writeback select
    // ------------------------------------------------------------------
    always_comb begin
        ld_byte = dm_rdata[7:0];
        case (lane)
            2'd0:    ld_byte = dm_rdata[7:0];
            2'd1:    ld_byte = dm_rdata[15:8];
            2'd2:    ld_byte = dm_rdata[23:16];
            default: ld_byte = dm_rdata[31:24];
        endcase
        ld_half = lane[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    end

    always_comb begin
        case (funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = dm_rdata;
        endcase
    end

    always_comb begin
        case (wb_sel)
            WB_ALU:  wb_val = addr;
            WB_LOAD: wb_val = load_val;
            WB_PC4:  wb_val = pc + 32'd4;
            default: wb_val = imm;
        endcase
    end

    // ------------------------------------------------------------------
    // MEM/WB output register
    // ------------------------------------------------------------------
    assign wb_load = ~rst & in_valid & (~mem_op | trap | complete);

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
            wb_rd_o    <= 5'd0;
            wb_data_o  <= 32'd0;
        end else if (wb_load) begin
            wb_valid_o <= 1'b1;
            wb_we_o    <= reg_write_en & (rd != 5'd0) & ~trap;
            wb_rd_o    <= rd;
            wb_data_o  <= wb_val;
        end else begin
            wb_valid_o <= 1'b0;
            wb_we_o    <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= wb_load & trap;
        end
    end
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: store-encoding table, directed corner
// sequences and randomized ops scored against a transaction-level model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        reg_write_en;
    logic [1:0]  wb_sel;
    logic        stall_o;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read),
        .mem_write(mem_write), .funct3(funct3), .addr(addr), .wdata(wdata),
        .pc(pc), .imm(imm), .rd(rd), .reg_write_en(reg_write_en), .wb_sel(wb_sel),
        .stall_o(stall_o), .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ready(dm_ready),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .wb_valid_o(wb_valid_o),
        .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o)
    );

`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          rd_op;
        bit          wr_op;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rdata;
        logic [4:0]  rd;
        bit          rwe;
        logic [1:0]  wsel;
        int          l1;     // cycles before dm_ready
        int          l2;     // further cycles until dm_rvalid (loads)
        bit          noise;  // spurious dm_rvalid where it must be ignored
    } op_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] wd;
    } svec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        int s;
        s = int'(f3) % 4;
        return (s == 0) ? 1 : (s == 1) ? 2 : 4;
    endfunction

    function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a % 32'd4) % size_bytes(f3)) != 0;
    endfunction

    function automatic int lane_of(input logic [2:0] f3, input logic [31:0] a);
        int nb;
        nb = size_bytes(f3);
        return (int'(a % 32'd4) / nb) * nb;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        int          nb;
        longint      v;
        logic [63:0] r;
        nb = size_bytes(f3);
        v  = longint'((64'(rdata) >> (8 * lane_of(f3, a))) & ((64'd1 << (8 * nb)) - 1));
        if (int'(f3) < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
            v = v - (longint'(1) << (8 * nb));
        r = 64'(v);
        return r[31:0];
    endfunction

    function automatic logic [3:0] exp_be(input op_t o);
        logic [7:0] b;
        if (!o.wr_op) return 4'hF;
        b = 8'(((1 << size_bytes(o.f3)) - 1) << lane_of(o.f3, o.addr));
        return b[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(input op_t o);
        int          nb;
        logic [63:0] m;
        nb = size_bytes(o.f3);
        m  = (64'(o.wdata) & ((64'd1 << (8 * nb)) - 1)) *
             ((nb == 1) ? 64'h01010101 : (nb == 2) ? 64'h00010001 : 64'd1);
        return m[31:0];
    endfunction

    function automatic logic [31:0] exp_wb(input op_t o);
        case (o.wsel)
            2'd0:    return o.addr;
            2'd1:    return exp_load(o.f3, o.addr, o.rdata);
            2'd2:    return o.pc + 32'd4;
            default: return o.imm;
        endcase
    endfunction

    function automatic op_t mk_op(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] rdata, input int l1, input int l2);
        op_t o;
        o.rd_op = rd_op;  o.wr_op = wr_op;  o.f3 = f3;  o.addr = a;  o.wdata = wd;
        o.rdata = rdata;  o.l1 = l1;  o.l2 = l2;  o.pc = 32'h0;  o.imm = 32'h0;
        o.rd = 5'd1;  o.rwe = rd_op;  o.wsel = rd_op ? 2'd1 : 2'd0;  o.noise = 1'b1;
        return o;
    endfunction

    // Drives one op (starting just after a rising edge), plays the memory side,
    // then checks the writeback pulse and the idle cycle that follows.
    task automatic run_op(input op_t o, output int stall_n, output logic first_req,
                          output logic [31:0] first_addr, output logic [31:0] wb_d);
        bit mem, trap, exp_req, proto_ok, done;
        int exp_stall, c;
        mem       = o.rd_op | o.wr_op;
        trap      = TRAP_EN && mem && is_misaligned(o.f3, o.addr);
        exp_stall = (!mem || trap) ? 0 : o.wr_op ? o.l1 : o.l1 + o.l2;
        proto_ok  = 1'b1;
        done      = 1'b0;
        stall_n   = 0;
        c         = 0;
        first_req = 1'b0;
        first_addr = 32'h0;
        in_valid = 1'b1;  mem_read = o.rd_op;  mem_write = o.wr_op;  funct3 = o.f3;
        addr = o.addr;  wdata = o.wdata;  pc = o.pc;  imm = o.imm;  rd = o.rd;
        reg_write_en = o.rwe;  wb_sel = o.wsel;
        while (!done) begin
            dm_ready = (c == o.l1);
            if (o.rd_op)
                dm_rvalid = (c == o.l1 + o.l2) || (o.noise && c < o.l1 && $urandom_range(0, 1) == 1);
            else
                dm_rvalid = o.noise && $urandom_range(0, 1) == 1;
            dm_rdata = (o.rd_op && c == o.l1 + o.l2) ? o.rdata : $urandom;
            @(negedge clk);
            exp_req = mem && !trap && (o.wr_op || c <= o.l1);
            if (dm_req !== exp_req) proto_ok = 1'b0;
            if (exp_req && (dm_addr !== {o.addr[31:2], 2'b00} || dm_we !== o.wr_op ||
                            dm_be !== exp_be(o) || (o.wr_op && dm_wdata !== exp_wd(o))))
                proto_ok = 1'b0;
            if (wb_valid_o !== 1'b0 || wb_we_o !== 1'b0) proto_ok = 1'b0;
            if (c == 0) begin
                first_req  = dm_req;
                first_addr = dm_addr;
            end
            if (stall_o === 1'b1) stall_n++;
            else begin
                done = 1'b1;
                if (stall_o !== 1'b0) proto_ok = 1'b0;
            end
            c++;
            if (c > 40) begin
                done     = 1'b1;
                proto_ok = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;  dm_ready = 1'b0;  dm_rvalid = 1'b0;
        check("protocol", 32'(proto_ok), 32'd1);
        check("stall_cycles", 32'(stall_n), 32'(exp_stall));
        check("wb_valid_pulse", 32'(wb_valid_o), 32'd1);
        check("wb_we", 32'(wb_we_o), 32'(o.rwe && o.rd != 5'd0 && !trap));
        check("wb_rd", 32'(wb_rd_o), 32'(o.rd));
        check("misalign", 32'(misalign_o), 32'(trap));
        if (!trap) check("wb_data", wb_data_o, exp_wb(o));
        wb_d = wb_data_o;
        @(posedge clk);
        #1;
        check("wb_valid_drop", 32'({wb_valid_o, wb_we_o}), 32'd0);
    endtask

    svec_t       tbl[8];
    op_t         o;
    int          st;
    logic        fr;
    logic [31:0] fa;
    logic [31:0] wd;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
        tbl[1] = '{3'b001, 32'h0000_0002, 32'h0000_ABCD, 4'b1100, 32'hABCD_ABCD};
        tbl[2] = '{3'b001, 32'h0000_0010, 32'h1234_5678, 4'b0011, 32'h5678_5678};
        tbl[3] = '{3'b000, 32'h0000_0001, 32'h0000_00A5, 4'b0010, 32'hA5A5_A5A5};
        tbl[4] = '{3'b000, 32'h0000_0003, 32'hFFFF_FF3C, 4'b1000, 32'h3C3C_3C3C};
        tbl[5] = '{3'b000, 32'h0000_0000, 32'h0000_0011, 4'b0001, 32'h1111_1111};
        tbl[6] = '{3'b000, 32'h0000_0022, 32'hCAFE_00E7, 4'b0100, 32'hE7E7_E7E7};
        tbl[7] = '{3'b010, 32'h0000_07FC, 32'h0123_4567, 4'b1111, 32'h0123_4567};

        // Reset with a load presented: no request, no stall, cleared outputs.
        rst = 1'b1;  in_valid = 1'b1;  mem_read = 1'b1;  mem_write = 1'b0;  funct3 = 3'b010;
        addr = 32'h40;  wdata = 32'h0;  pc = 32'h0;  imm = 32'h0;  rd = 5'd7;
        reg_write_en = 1'b1;  wb_sel = 2'd1;  dm_ready = 1'b0;  dm_rvalid = 1'b0;  dm_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dm_req", 32'(dm_req), 32'd0);
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        check("rst_wb_we", 32'(wb_we_o), 32'd0);
        check("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        check("rst_wb_data", wb_data_o, 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        rst = 1'b0;  in_valid = 1'b0;
        @(posedge clk);
        #1;

        // Store encoding table, each accepted in the cycle it is presented.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;  mem_read = 1'b0;  mem_write = 1'b1;  funct3 = tbl[i].f3;
            addr = tbl[i].addr;  wdata = tbl[i].wdata;  reg_write_en = 1'b0;  wb_sel = 2'd0;
            dm_ready = 1'b1;
            @(negedge clk);
            check("tbl_dm_req", 32'(dm_req), 32'd1);
            check("tbl_dm_be", 32'(dm_be), 32'(tbl[i].be));
            check("tbl_dm_wdata", dm_wdata, tbl[i].wd);
            check("tbl_dm_addr", dm_addr, {tbl[i].addr[31:2], 2'b00});
            check("tbl_stall", 32'(stall_o), 32'd0);
            @(posedge clk);
            #1;
            check("tbl_wb", 32'({wb_valid_o, wb_we_o}), 32'b10);
        end
        in_valid = 1'b0;  dm_ready = 1'b0;
        @(posedge clk);
        #1;
        check("tbl_wb_drop", 32'(wb_valid_o), 32'd0);

        // LB at 0x203: ready on cycle 2, response 4 cycles later -> 6 stall cycles.
        o = mk_op(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 32'h8011_2233, 2, 4);
        run_op(o, st, fr, fa, wd);
        check("lb_stall6", 32'(st), 32'd6);
        check("lb_sext", wd, 32'hFFFF_FF80);

        // pc+4 wraps to zero, no memory access.
        o = mk_op(1'b0, 1'b0, 3'b000, 32'h1234, 32'h0, 32'h0, 0, 0);
        o.wsel = 2'd2;  o.pc = 32'hFFFF_FFFC;  o.rwe = 1'b1;  o.rd = 5'd9;
        run_op(o, st, fr, fa, wd);
        check("pc4_stall", 32'(st), 32'd0);
        check("pc4_wrap", wd, 32'h0);

        // LW at 0x06: trapped with the option, else word at 0x04.
        o = mk_op(1'b1, 1'b0, 3'b010, 32'h6, 32'h0, 32'h1234_5678, 1, 1);
        o.rd = 5'd5;
        run_op(o, st, fr, fa, wd);
        if (TRAP_EN) begin
            check("lw_mis_no_req", 32'(fr), 32'd0);
        end else begin
            check("lw_mis_addr", fa, 32'h4);
            check("lw_mis_data", wd, 32'h1234_5678);
        end

        // Reset while waiting for a load response; the late response is ignored.
        in_valid = 1'b1;  mem_read = 1'b1;  mem_write = 1'b0;  funct3 = 3'b010;
        addr = 32'h40;  rd = 5'd3;  reg_write_en = 1'b1;  wb_sel = 2'd1;
        dm_ready = 1'b1;  dm_rvalid = 1'b0;
        @(negedge clk);
        check("wrst_req", 32'(dm_req), 32'd1);
        @(posedge clk);
        #1;
        dm_ready = 1'b0;  rst = 1'b1;
        #1;
        check("wrst_gate", 32'({dm_req, stall_o}), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;  dm_rvalid = 1'b1;  dm_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        check("wrst_idle_req", 32'(dm_req), 32'd1);
        check("wrst_stall", 32'(stall_o), 32'd1);
        check("wrst_wb_valid", 32'(wb_valid_o), 32'd0);
        in_valid = 1'b0;  dm_rvalid = 1'b0;
        @(posedge clk);
        #1;
        check("wrst_ignored", 32'({wb_valid_o, wb_we_o}), 32'd0);

        // Randomized ops against the model.
        for (int n = 0; n < 200; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            o = mk_op(kind == 1, kind == 2, 3'($urandom_range(0, 2)), $urandom, $urandom,
                      $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
            if ($urandom_range(0, 1) == 1) o.addr[1:0] = 2'b00;
            o.pc   = $urandom;
            o.imm  = $urandom;
            o.rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            o.wsel = 2'($urandom_range(0, 2));
            if (o.wsel != 2'd0) o.wsel = o.wsel + 2'd1;
            if (kind == 1) begin
                case ($urandom_range(0, 4))
                    0: o.f3 = 3'b000;
                    1: o.f3 = 3'b001;
                    2: o.f3 = 3'b010;
                    3: o.f3 = 3'b100;
                    default: o.f3 = 3'b101;
                endcase
                o.rwe  = 1'b1;
                o.wsel = 2'd1;
            end else if (kind == 2) begin
                o.rwe = 1'b0;
            end else begin
                o.rwe = 1'($urandom_range(0, 1));
            end
            run_op(o, st, fr, fa, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
